// File: rtl/shift_reg_pkg.sv
// Shared types for shift_reg_burst: FSM state encoding and shift direction constants.
// Pure declarations, no logic.
package shift_reg_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shift_reg_burst_shift_step.sv
// One-position shift of a WIDTH-bit word with serial fill or rotate.
// Purely combinational, zero latency, no flow control.
module shift_step
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] din,
  input  logic             dir,
  input  logic             rot,
  input  logic             sin,
  output logic [WIDTH-1:0] dout,
  output logic             bout
);

  logic fill;

  always_comb begin
    bout = 1'b0;
    fill = 1'b0;
    dout = din;
    if (dir == DIR_LEFT) begin
      bout = din[WIDTH-1];
      fill = rot ? bout : sin;
      dout = {din[WIDTH-2:0], fill};
    end else begin
      bout = din[0];
      fill = rot ? bout : sin;
      dout = {fill, din[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/shift_reg_burst.sv
// Parallel-load shift register running programmable bursts of LEN shifts, BUSY/DONE status.
// First shift on the START edge; LOAD/START are dropped (not queued) while a burst runs.
module shift_reg_burst
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = 4
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] PIN,
  input  logic             START,
  input  logic [CW-1:0]    LEN,
  input  logic             DIR,
  input  logic             ROT,
  input  logic             SIN,
  output logic [WIDTH-1:0] DOUT,
  output logic             SOUT,
  output logic             BUSY,
  output logic             DONE
);

  localparam logic [CW-1:0] CNT_ZERO = '0;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t          state;
  logic [CW-1:0]   remaining;
  logic            dir_q;
  logic            rot_q;
  logic            step_dir;
  logic            step_rot;
  logic [WIDTH-1:0] step_dout;
  logic            step_bout;

  // The START edge shifts with the live DIR/ROT; later edges use the captured copies.
  assign step_dir = (state == ST_IDLE) ? DIR : dir_q;
  assign step_rot = (state == ST_IDLE) ? ROT : rot_q;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .din  (DOUT),
    .dir  (step_dir),
    .rot  (step_rot),
    .sin  (SIN),
    .dout (step_dout),
    .bout (step_bout)
  );

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state     <= ST_IDLE;
      remaining <= CNT_ZERO;
      dir_q     <= DIR_LEFT;
      rot_q     <= 1'b0;
      DOUT      <= '0;
      SOUT      <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (LOAD) begin
            DOUT <= PIN;
          end else if (START) begin
            dir_q <= DIR;
            rot_q <= ROT;
            if (LEN == CNT_ZERO) begin
              DONE <= 1'b1;
            end else begin
              DOUT <= step_dout;
              SOUT <= step_bout;
              if (LEN == CNT_ONE) begin
                DONE <= 1'b1;
              end else begin
                remaining <= LEN - CNT_ONE;
                state     <= ST_RUN;
                BUSY      <= 1'b1;
              end
            end
          end
        end
        ST_RUN: begin
          DOUT      <= step_dout;
          SOUT      <= step_bout;
          remaining <= remaining - CNT_ONE;
          if (remaining == CNT_ONE) begin
            state <= ST_IDLE;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_reg_burst.sv
// Directed bench for shift_reg_burst (WIDTH=8, CW=4) with hand-computed expectations.
module tb_shift_reg_burst;

  logic       CLK = 1'b0;
  logic       CLR, LOAD, START, DIR, ROT, SIN;
  logic [7:0] PIN;
  logic [3:0] LEN;
  logic [7:0] DOUT;
  logic       SOUT, BUSY, DONE;

  int nvec = 0;
  int nerr = 0;

  shift_reg_burst #(.WIDTH(8), .CW(4)) dut (
    .CLK(CLK), .CLR(CLR), .LOAD(LOAD), .PIN(PIN), .START(START), .LEN(LEN),
    .DIR(DIR), .ROT(ROT), .SIN(SIN), .DOUT(DOUT), .SOUT(SOUT), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] d, input logic s,
                         input logic b, input logic dn);
    chk({tag, ".dout"}, DOUT, d);
    chk({tag, ".sout"}, {7'd0, SOUT}, {7'd0, s});
    chk({tag, ".busy"}, {7'd0, BUSY}, {7'd0, b});
    chk({tag, ".done"}, {7'd0, DONE}, {7'd0, dn});
  endtask

  initial begin
    CLR = 1'b1; LOAD = 1'b0; START = 1'b0; DIR = 1'b0; ROT = 1'b0; SIN = 1'b0;
    PIN = 8'h00; LEN = 4'd0;
    #1;
    step(); step();
    CLR = 1'b0;
    chk_all("reset", 8'h00, 1'b0, 1'b0, 1'b0);

    // parallel load
    LOAD = 1'b1; PIN = 8'hA5;
    step();
    LOAD = 1'b0;
    chk_all("load_a5", 8'hA5, 1'b0, 1'b0, 1'b0);

    // left, serial fill with 1, LEN=3
    START = 1'b1; LEN = 4'd3; DIR = 1'b0; ROT = 1'b0; SIN = 1'b1;
    step();
    START = 1'b0;
    chk_all("lf_e1", 8'h4B, 1'b1, 1'b1, 1'b0);
    step();
    chk_all("lf_e2", 8'h97, 1'b0, 1'b1, 1'b0);
    step();
    chk_all("lf_e3", 8'h2F, 1'b1, 1'b0, 1'b1);
    step();
    chk_all("lf_after", 8'h2F, 1'b1, 1'b0, 1'b0);

    // right rotate, LEN=4
    LOAD = 1'b1; PIN = 8'h81;
    step();
    LOAD = 1'b0;
    START = 1'b1; LEN = 4'd4; DIR = 1'b1; ROT = 1'b1; SIN = 1'b0;
    step();
    START = 1'b0;
    chk_all("rr_e1", 8'hC0, 1'b1, 1'b1, 1'b0);
    step();
    chk_all("rr_e2", 8'h60, 1'b0, 1'b1, 1'b0);
    step();
    chk_all("rr_e3", 8'h30, 1'b0, 1'b1, 1'b0);
    step();
    chk_all("rr_e4", 8'h18, 1'b0, 1'b0, 1'b1);
    step();
    chk("rr_done_drop", {7'd0, DONE}, 8'h00);

    // full rotation, LEN=8, SIN toggled to show it is ignored
    LOAD = 1'b1; PIN = 8'h81;
    step();
    LOAD = 1'b0;
    START = 1'b1; LEN = 4'd8; DIR = 1'b1; ROT = 1'b1; SIN = 1'b1;
    step();
    START = 1'b0;
    for (int i = 1; i < 8; i++) begin
      chk("rot8_busy", {7'd0, BUSY}, 8'h01);
      chk("rot8_nodone", {7'd0, DONE}, 8'h00);
      SIN = ~SIN;
      step();
    end
    chk_all("rot8_end", 8'h81, 1'b1, 1'b0, 1'b1);

    // LEN=0: no shift, DONE pulse only
    START = 1'b1; LEN = 4'd0; DIR = 1'b0; ROT = 1'b0; SIN = 1'b0;
    step();
    START = 1'b0;
    chk_all("len0", 8'h81, 1'b1, 1'b0, 1'b1);
    step();
    chk_all("len0_after", 8'h81, 1'b1, 1'b0, 1'b0);

    // LEN=1: one shift, BUSY never high
    START = 1'b1; LEN = 4'd1; DIR = 1'b0; ROT = 1'b0; SIN = 1'b0;
    step();
    START = 1'b0;
    chk_all("len1", 8'h02, 1'b1, 1'b0, 1'b1);
    step();
    chk_all("len1_after", 8'h02, 1'b1, 1'b0, 1'b0);

    // CLR aborts a burst after the 2nd shift
    LOAD = 1'b1; PIN = 8'hA5;
    step();
    LOAD = 1'b0;
    START = 1'b1; LEN = 4'd5; DIR = 1'b0; ROT = 1'b0; SIN = 1'b1;
    step();
    START = 1'b0;
    chk("abort_e1", DOUT, 8'h4B);
    step();
    chk("abort_e2", DOUT, 8'h97);
    CLR = 1'b1;
    step();
    CLR = 1'b0;
    chk_all("abort_clr", 8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("abort_nodone", {7'd0, DONE}, 8'h00);
      chk("abort_dout", DOUT, 8'h00);
    end

    // LOAD/START/DIR/ROT/LEN changes during RUN are ignored
    LOAD = 1'b1; PIN = 8'hA5;
    step();
    LOAD = 1'b0;
    START = 1'b1; LEN = 4'd3; DIR = 1'b1; ROT = 1'b0; SIN = 1'b0;
    step();
    chk_all("ign_e1", 8'h52, 1'b1, 1'b1, 1'b0);
    LOAD = 1'b1; PIN = 8'hFF; START = 1'b1; LEN = 4'd0; DIR = 1'b0; ROT = 1'b1;
    step();
    chk_all("ign_e2", 8'h29, 1'b0, 1'b1, 1'b0);
    LOAD = 1'b0; START = 1'b0;
    step();
    chk_all("ign_e3", 8'h14, 1'b1, 1'b0, 1'b1);

    // LOAD and START together in IDLE: load wins, START dropped
    LOAD = 1'b1; PIN = 8'h3C; START = 1'b1; LEN = 4'd2; DIR = 1'b0; ROT = 1'b0;
    step();
    LOAD = 1'b0; START = 1'b0;
    chk_all("ld_st", 8'h3C, 1'b1, 1'b0, 1'b0);
    step();
    chk_all("ld_st_after", 8'h3C, 1'b1, 1'b0, 1'b0);

    // back-to-back: START in the DONE cycle
    START = 1'b1; LEN = 4'd1; DIR = 1'b0; ROT = 1'b1;
    step();
    chk_all("b2b_first", 8'h78, 1'b0, 1'b0, 1'b1);
    LEN = 4'd2; DIR = 1'b1; ROT = 1'b1;
    step();
    START = 1'b0;
    chk_all("b2b_e1", 8'h3C, 1'b0, 1'b1, 1'b0);
    step();
    chk_all("b2b_e2", 8'h1E, 1'b0, 1'b0, 1'b1);
    step();
    chk_all("b2b_after", 8'h1E, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/shift_reg_burst.md
Name: shift_reg_burst

Overview:
- Parametrised successor to the team's 4-bit serial-in shift registers.
- Holds a WIDTH-bit register that supports parallel load, left or right shifting, serial fill or rotate, and a programmable burst of LEN shifts.
- A small FSM runs the burst and reports BUSY and a one-cycle DONE pulse.
- Used as the serialiser/deserialiser and bit-rotator in the Project2 datapath.

Parameters:
- WIDTH, 8, register width in bits (>= 2).
- CW, 4, width of LEN; a burst runs 0 to 2^CW-1 shifts (may exceed WIDTH when rotating).

Ports:
- CLK  in  1  clock; all state changes on its rising edge.
- CLR  in  1  synchronous active-high reset; highest priority.
- LOAD  in  1  parallel-load strobe; honoured only in IDLE.
- PIN  in  WIDTH  parallel load data.
- START  in  1  burst start strobe; honoured only in IDLE.
- LEN  in  CW  shift count, captured with START.
- DIR  in  1  0 = left (toward MSB), 1 = right; captured with START.
- ROT  in  1  0 = serial fill from SIN, 1 = rotate; captured with START.
- SIN  in  1  serial input, sampled on every shift edge when ROT=0.
- DOUT  out  WIDTH  register contents.
- SOUT  out  1  registered bit that left the register on the most recent shift.
- BUSY  out  1  high while shifts of the current burst remain.
- DONE  out  1  one-cycle pulse when a burst completes.

Behaviour:
- One clock, CLK. Reset CLR is synchronous and active-high.
- Reset values:
  - DOUT=0, SOUT=0, BUSY=0, DONE=0.
  - State=IDLE, remaining count=0.
- Priority at each edge: CLR > LOAD > START.
- CLR in the middle of a burst aborts it: DOUT=0 and no DONE pulse.
- States are IDLE and RUN.
- IDLE:
  - LOAD=1 gives DOUT<=PIN. Any START in the same cycle is dropped.
  - Otherwise START=1 captures DIR and ROT and performs the first shift on that same edge, using the SIN of that cycle.
  - After that edge, with n=LEN:
    - n=0: no shift, DOUT unchanged, DONE=1, BUSY=0, stay IDLE.
    - n=1: one shift done, DONE=1, BUSY=0, stay IDLE.
    - n>1: remaining=n-1, go to RUN, BUSY=1.
- RUN:
  - Shift on every edge and decrement remaining.
  - The edge where remaining goes 1->0 performs the last shift, then: IDLE, BUSY=0, DONE=1 for exactly one cycle.
  - Result: n shifts occur on edges k..k+n-1, and DONE is high in the cycle after edge k+n-1.
- LOAD and START are ignored while in RUN; they are not queued.
- Shift rule:
  - Left: DOUT<={DOUT[W-2:0], b} and SOUT<=old DOUT[W-1].
  - Right: DOUT<={b, DOUT[W-1:1]} and SOUT<=old DOUT[0].
  - b=SIN when ROT=0. b=the outgoing bit when ROT=1, and SIN is ignored.
- SOUT changes only on shift edges. LOAD leaves SOUT unchanged.
- Back-to-back bursts: START in the cycle where DONE=1 is accepted, since the state is IDLE. DONE then drops unless the new LEN is 0 or 1.
- DIR, ROT and LEN changes during RUN have no effect.
- All registers use non-blocking assignment; no asynchronous paths.

Decomposition:
- shift_reg_pkg holds:
  - the state enum (ST_IDLE, ST_RUN);
  - the direction constants (DIR_LEFT=0, DIR_RIGHT=1).
- One combinational sub-module, shift_step, computes the next DOUT and outgoing bit from DOUT, DIR, ROT and SIN. It is reused by the LOAD/START path and by the RUN path.
- The FSM, counter and output registers stay in the top module.

Test Plan (WIDTH=8, CW=4):
- CLR, then LOAD PIN=8'hA5 -> DOUT=A5 after one edge; BUSY=0; DONE=0; SOUT=0.
- From A5: START LEN=3, DIR=0, ROT=0, SIN=1 held -> DOUT sequence 4B, 97, 2F. SOUT sequence 1, 0, 1. BUSY=1 after edges 1–2. DONE high for exactly one cycle after edge 3.
- LOAD 8'h81, START LEN=4, DIR=1, ROT=1 -> DOUT sequence C0, 60, 30, 18. LEN=8 on 81 returns to 81 with DONE.
- START LEN=0 -> DOUT unchanged, DONE pulses for one cycle, BUSY stays 0. LEN=1 -> one shift, DONE, BUSY never high.
- Burst LEN=5 from A5 with CLR asserted after the 2nd shift -> DOUT=00, BUSY=0, no DONE. LOAD/START pulsed during BUSY in a separate burst -> ignored; that burst completes normally.
- LOAD=1 with START=1 in IDLE -> load only, no DONE. START asserted in the DONE cycle -> new burst starts on that edge.
